// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and stall sequencer for a 5-stage RV32 pipeline. It drives the
// hold, bubble and flush controls of the PC, IF/ID and ID/EX registers, and
// freezes EX/MEM and later registers while data memory is busy.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   rs1/rs2_raddr_ID      : source register addresses of the instruction in ID
//   rs1/rs2_used_ID       : the ID instruction actually reads that source
//   rd_waddr_EX, rd_wen_EX: destination and write enable of the instruction in EX
//   load_EX               : the EX instruction is a load
//   redirect_EX           : taken branch / jal / jalr resolved in EX
//   mem_busy              : data memory not ready this cycle
//   clr_cnt               : synchronous clear of both performance counters
//   pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, pipe_freeze
//                         : combinational pipeline controls
//   mem_timeout           : sticky, mem_busy lasted MEM_TIMEOUT cycles
//   stall_cnt, flush_cnt  : saturating counts of pc_stall / ifid_flush cycles
module pipe_hazard_ctrl #(
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_raddr_ID,
    input  logic [4:0]       rs2_raddr_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_waddr_EX,
    input  logic             rd_wen_EX,
    input  logic             load_EX,
    input  logic             redirect_EX,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t              r_state, r_ret_state;
    logic [1:0]          r_bub_rem;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mem_timeout;
    logic [CNT_W-1:0]    r_stall_cnt, r_flush_cnt;

    state_t              w_nxt_state, w_nxt_ret, w_eff_state;
    logic [1:0]          w_nxt_bub;
    logic [WAIT_W-1:0]   w_nxt_wait;
    logic                w_hz;
    logic                w_pc_stall, w_ifid_stall, w_ifid_flush;
    logic                w_idex_stall, w_idex_bubble, w_pipe_freeze;

    // Load-use hazard; x0 is never a real destination.
    assign w_hz = load_EX && rd_wen_EX && (rd_waddr_EX != 5'd0) &&
                  ((rs1_used_ID && (rs1_raddr_ID == rd_waddr_EX)) ||
                   (rs2_used_ID && (rs2_raddr_ID == rd_waddr_EX)));

    // Once memory is ready again, decide as if still in the interrupted state.
    assign w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;

    // NOTE: every signal gets a default at the top so no path infers a latch;
    // combinational blocks use blocking assignments.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_ret     = r_ret_state;
        w_nxt_bub     = r_bub_rem;
        w_nxt_wait    = r_wait_cnt;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_freeze = 1'b0;

        if (mem_busy) begin
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_pipe_freeze = 1'b1;
            w_nxt_state   = MEM_WAIT;
            w_nxt_ret     = w_eff_state;
            if (r_wait_cnt != '1)
                w_nxt_wait = r_wait_cnt + WAIT_W'(1);
        end else begin
            w_nxt_wait = '0;
            if (redirect_EX) begin
                // PC must load the target, so no stall; younger work is squashed.
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
                w_nxt_state   = RUN;
                w_nxt_bub     = 2'd0;
            end else if (w_eff_state == LD_STALL) begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_bubble = 1'b1;
                w_nxt_bub     = r_bub_rem - 2'd1;
                w_nxt_state   = (r_bub_rem == 2'd1) ? RUN : LD_STALL;
            end else if (w_hz) begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_bubble = 1'b1;
                if (LOAD_BUBBLES > 1) begin
                    w_nxt_state = LD_STALL;
                    w_nxt_bub   = 2'(LOAD_BUBBLES - 1);
                end else begin
                    w_nxt_state = RUN;
                end
            end else begin
                w_nxt_state = RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_ret_state   <= RUN;
            r_bub_rem     <= 2'd0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_ret_state <= w_nxt_ret;
            r_bub_rem   <= w_nxt_bub;
            r_wait_cnt  <= w_nxt_wait;
            if (mem_busy && (w_nxt_wait >= WAIT_W'(MEM_TIMEOUT)))
                r_mem_timeout <= 1'b1;
            if (clr_cnt) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (w_pc_stall && (r_stall_cnt != '1))
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                if (w_ifid_flush && (r_flush_cnt != '1))
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // Controls are forced low for as long as reset is asserted.
    assign pc_stall    = rst_n & w_pc_stall;
    assign ifid_stall  = rst_n & w_ifid_stall;
    assign ifid_flush  = rst_n & w_ifid_flush;
    assign idex_stall  = rst_n & w_idex_stall;
    assign idex_bubble = rst_n & w_idex_bubble;
    assign pipe_freeze = rst_n & w_pipe_freeze;
    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Two instances share the stimulus:
//   u_d1: LOAD_BUBBLES=1, MEM_TIMEOUT=255, CNT_W=16
//   u_d3: LOAD_BUBBLES=3, MEM_TIMEOUT=4,   CNT_W=3 (small counters for saturation)
// Control vectors are packed as
//   {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, pipe_freeze}.
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_BUBBLE = 6'b110010;
    localparam logic [5:0] C_FLUSH  = 6'b001010;
    localparam logic [5:0] C_FREEZE = 6'b110101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_raddr_ID, rs2_raddr_ID, rd_waddr_EX;
    logic       rs1_used_ID, rs2_used_ID, rd_wen_EX, load_EX;
    logic       redirect_EX, mem_busy, clr_cnt;

    logic        d1_pc_stall, d1_ifid_stall, d1_ifid_flush, d1_idex_stall;
    logic        d1_idex_bubble, d1_pipe_freeze, d1_mem_timeout;
    logic [15:0] d1_stall_cnt, d1_flush_cnt;
    logic        d3_pc_stall, d3_ifid_stall, d3_ifid_flush, d3_idex_stall;
    logic        d3_idex_bubble, d3_pipe_freeze, d3_mem_timeout;
    logic [2:0]  d3_stall_cnt, d3_flush_cnt;

    logic [5:0] d1_ctrl, d3_ctrl;
    assign d1_ctrl = {d1_pc_stall, d1_ifid_stall, d1_ifid_flush,
                      d1_idex_stall, d1_idex_bubble, d1_pipe_freeze};
    assign d3_ctrl = {d3_pc_stall, d3_ifid_stall, d3_ifid_flush,
                      d3_idex_stall, d3_idex_bubble, d3_pipe_freeze};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .rs1_raddr_ID(rs1_raddr_ID), .rs2_raddr_ID(rs2_raddr_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_waddr_EX(rd_waddr_EX), .rd_wen_EX(rd_wen_EX), .load_EX(load_EX),
        .redirect_EX(redirect_EX), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .pc_stall(d1_pc_stall), .ifid_stall(d1_ifid_stall),
        .ifid_flush(d1_ifid_flush), .idex_stall(d1_idex_stall),
        .idex_bubble(d1_idex_bubble), .pipe_freeze(d1_pipe_freeze),
        .mem_timeout(d1_mem_timeout), .stall_cnt(d1_stall_cnt),
        .flush_cnt(d1_flush_cnt)
    );

    pipe_hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(3)) u_d3 (
        .clk(clk), .rst_n(rst_n),
        .rs1_raddr_ID(rs1_raddr_ID), .rs2_raddr_ID(rs2_raddr_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_waddr_EX(rd_waddr_EX), .rd_wen_EX(rd_wen_EX), .load_EX(load_EX),
        .redirect_EX(redirect_EX), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .pc_stall(d3_pc_stall), .ifid_stall(d3_ifid_stall),
        .ifid_flush(d3_ifid_flush), .idex_stall(d3_idex_stall),
        .idex_bubble(d3_idex_bubble), .pipe_freeze(d3_pipe_freeze),
        .mem_timeout(d3_mem_timeout), .stall_cnt(d3_stall_cnt),
        .flush_cnt(d3_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples then sit 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_raddr_ID = 5'd0; rs2_raddr_ID = 5'd0;
        rs1_used_ID  = 1'b0; rs2_used_ID  = 1'b0;
        rd_waddr_EX  = 5'd0; rd_wen_EX    = 1'b0; load_EX = 1'b0;
        redirect_EX  = 1'b0; mem_busy     = 1'b0; clr_cnt = 1'b0;
    endtask

    // Load in EX writing rd, ID instruction reading rs1=rs.
    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs);
        idle();
        load_EX = 1'b1; rd_wen_EX = 1'b1; rd_waddr_EX = rd;
        rs1_raddr_ID = rs; rs1_used_ID = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        check("rst_d1_ctrl", d1_ctrl, C_IDLE);
        check("rst_d3_ctrl", d3_ctrl, C_IDLE);
        check("rst_d1_cnts", {d1_stall_cnt, d1_flush_cnt}, 32'd0);
        check("rst_d3_tmo",  d3_mem_timeout, 1'b0);
        #1 rst_n = 1'b1;
        tick();

        // Single-bubble load-use on rs1, then rs2, then non-hazards.
        load_use(5'd5, 5'd5); #1;
        check("lb1_hz_rs1", d1_ctrl, C_BUBBLE);
        tick(); idle(); #1;
        check("lb1_after", d1_ctrl, C_IDLE);
        check("lb1_cnt", d1_stall_cnt, 16'd1);
        load_use(5'd7, 5'd3); rs2_raddr_ID = 5'd7; rs2_used_ID = 1'b1; #1;
        check("lb1_hz_rs2", d1_ctrl, C_BUBBLE);
        rs2_used_ID = 1'b0; #1;
        check("lb1_rs2_unused", d1_ctrl, C_IDLE);
        load_use(5'd5, 5'd5); rd_wen_EX = 1'b0; #1;
        check("lb1_no_wen", d1_ctrl, C_IDLE);
        load_use(5'd5, 5'd5); load_EX = 1'b0; #1;
        check("lb1_not_load", d1_ctrl, C_IDLE);
        tick();
        check("lb1_cnt_hold", d1_stall_cnt, 16'd1);

        // Three-bubble load-use, then x0 never stalls.
        do_reset();
        load_use(5'd5, 5'd5); #1;
        check("lb3_b1", d3_ctrl, C_BUBBLE);
        tick(); idle(); #1;
        check("lb3_b2", d3_ctrl, C_BUBBLE);
        tick(); #1;
        check("lb3_b3", d3_ctrl, C_BUBBLE);
        tick(); #1;
        check("lb3_done", d3_ctrl, C_IDLE);
        check("lb3_cnt", d3_stall_cnt, 3'd3);
        load_use(5'd0, 5'd0); #1;
        check("x0_no_hz", d3_ctrl, C_IDLE);
        tick(); idle();
        check("x0_cnt", d3_stall_cnt, 3'd3);

        // Redirect pulse, then redirect on the second bubble of a load stall.
        redirect_EX = 1'b1; #1;
        check("redir_ctrl", d3_ctrl, C_FLUSH);
        tick(); idle(); #1;
        check("redir_after", d3_ctrl, C_IDLE);
        check("redir_fcnt", d3_flush_cnt, 3'd1);
        load_use(5'd9, 5'd9); #1;
        check("redir_hz", d3_ctrl, C_BUBBLE);
        tick(); idle(); redirect_EX = 1'b1; #1;
        check("redir_wins", d3_ctrl, C_FLUSH);
        tick(); idle(); #1;
        check("redir_no_b3", d3_ctrl, C_IDLE);
        check("redir_fcnt2", d3_flush_cnt, 3'd2);
        check("redir_scnt", d3_stall_cnt, 3'd4);

        // Memory wait in the middle of a load stall; clr on the hazard cycle.
        do_reset();
        load_use(5'd5, 5'd5); clr_cnt = 1'b1; #1;
        check("mw_hz", d3_ctrl, C_BUBBLE);
        tick(); idle(); mem_busy = 1'b1; #1;
        check("clr_vs_stall", d3_stall_cnt, 3'd0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("mw_freeze%0d", i), d3_ctrl, C_FREEZE);
            tick();
            if (i == 3) check("mw_tmo_before", d3_mem_timeout, 1'b0);
        end
        check("mw_tmo_set", d3_mem_timeout, 1'b1);
        check("mw_d1_no_tmo", d1_mem_timeout, 1'b0);
        mem_busy = 1'b0; #1;
        check("mw_resume_b2", d3_ctrl, C_BUBBLE);
        tick(); #1;
        check("mw_resume_b3", d3_ctrl, C_BUBBLE);
        tick(); #1;
        check("mw_done", d3_ctrl, C_IDLE);
        check("mw_scnt", d3_stall_cnt, 3'd6);
        check("mw_fcnt", d3_flush_cnt, 3'd0);

        // Long busy: timeout on the 4th cycle, counter saturation, stickiness.
        do_reset();
        mem_busy = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 3) check("to_edge3", d3_mem_timeout, 1'b0);
            if (i == 4) check("to_edge4", d3_mem_timeout, 1'b1);
            if (i == 7) check("sat_7", d3_stall_cnt, 3'd7);
        end
        check("sat_hold", d3_stall_cnt, 3'd7);
        check("d1_cnt9", d1_stall_cnt, 16'd9);
        mem_busy = 1'b0; #1;
        check("to_exit_ctrl", d3_ctrl, C_IDLE);
        tick(); tick();
        check("to_sticky", d3_mem_timeout, 1'b1);
        clr_cnt = 1'b1;
        tick(); clr_cnt = 1'b0;
        check("clr_cnt", d3_stall_cnt, 3'd0);
        check("clr_keeps_tmo", d3_mem_timeout, 1'b1);
        rst_n = 1'b0; #1;
        check("to_rst_clear", d3_mem_timeout, 1'b0);
        #1 rst_n = 1'b1;
        tick();

        // Asynchronous reset in LD_STALL and in MEM_WAIT.
        load_use(5'd5, 5'd5);
        tick(); idle(); #1;
        check("ar_ld_pre", d3_ctrl, C_BUBBLE);
        rst_n = 1'b0; #1;
        check("ar_ld_ctrl", d3_ctrl, C_IDLE);
        check("ar_ld_cnt", d3_stall_cnt, 3'd0);
        #1 rst_n = 1'b1;
        tick(); #1;
        check("ar_ld_run", d3_ctrl, C_IDLE);
        mem_busy = 1'b1; #1;
        check("ar_mw_pre", d3_ctrl, C_FREEZE);
        tick();
        rst_n = 1'b0; #1;
        check("ar_mw_ctrl", d3_ctrl, C_IDLE);
        check("ar_mw_d1", d1_ctrl, C_IDLE);
        mem_busy = 1'b0;
        #1 rst_n = 1'b1;
        tick(); #1;
        check("ar_mw_run", d3_ctrl, C_IDLE);
        check("ar_mw_tmo", d3_mem_timeout, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and stall sequencer for the 5-stage RV32 pipeline. It drives the hold, bubble and flush controls of the PC, IF/ID and ID/EX registers, and the freeze of EX/MEM and later registers.
- Detects load-use hazards between the instruction in ID and a load in EX.
- Squashes younger instructions when EX redirects the PC (taken branch, jal, jalr).
- Freezes the pipeline while data memory is busy.
- Keeps saturating stall and flush performance counters, plus a sticky memory-timeout flag.

Parameters:
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3).
MEM_TIMEOUT, 255, consecutive mem_busy cycles tolerated before mem_timeout sets (legal 1..65535).
CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1_raddr_ID  in  5  rs1 address of instruction in ID
rs2_raddr_ID  in  5  rs2 address of instruction in ID
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
rd_waddr_EX  in  5  destination of instruction in EX
rd_wen_EX  in  1  EX instruction writes rd
load_EX  in  1  EX instruction is a load
redirect_EX  in  1  taken branch, jal or jalr resolved in EX
mem_busy  in  1  data memory not ready this cycle
clr_cnt  in  1  synchronous clear of both counters
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  load a NOP into IF/ID
idex_stall  out  1  hold ID/EX
idex_bubble  out  1  load ID/EX with zeroed control (rd_wen, MemWrite, branch, jal, jalr = 0)
pipe_freeze  out  1  hold EX/MEM and MEM/WB
mem_timeout  out  1  sticky: mem_busy exceeded MEM_TIMEOUT
stall_cnt  out  CNT_W  cycles with pc_stall=1
flush_cnt  out  CNT_W  cycles with ifid_flush=1

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- While rst_n=0:
  - state=RUN, bub_rem=0, wait_cnt=0.
  - Counters are 0 and mem_timeout=0.
  - All stall, flush, bubble and freeze outputs are forced to 0.
- Stall, flush, bubble and freeze outputs are combinational from the current state and inputs, so they take effect the same cycle. State and counters update on the rising clk edge.
- Hazard term: hz = load_EX & rd_wen_EX & (rd_waddr_EX != 0) & ((rs1_used_ID & rs1_raddr_ID == rd_waddr_EX) | (rs2_used_ID & rs2_raddr_ID == rd_waddr_EX)).
- Priority, highest first: mem_busy, then redirect_EX, then hz or LD_STALL.
- mem_busy=1, in any state:
  - Outputs: pc_stall, ifid_stall, idex_stall, pipe_freeze = 1; bubble and flush = 0.
  - FSM: state becomes MEM_WAIT; ret_state captures the pre-wait state (held if already MEM_WAIT); bub_rem is held.
  - wait_cnt increments, saturating. When wait_cnt reaches MEM_TIMEOUT while mem_busy=1, mem_timeout sets and stays set until reset.
- mem_busy=0 in MEM_WAIT: clear wait_cnt, then evaluate the rules below as if in ret_state, in the same cycle.
- redirect_EX=1, without mem_busy:
  - Outputs: ifid_flush=1, idex_bubble=1; pc_stall, ifid_stall = 0 so the PC loads the target.
  - FSM: next state RUN, bub_rem=0. This aborts any pending load bubbles.
- hz=1 in RUN:
  - Outputs: pc_stall, ifid_stall, idex_bubble = 1.
  - FSM: if LOAD_BUBBLES=1, stay RUN. Otherwise go to LD_STALL with bub_rem = LOAD_BUBBLES-1.
- LD_STALL:
  - Outputs: pc_stall, ifid_stall, idex_bubble = 1.
  - FSM: bub_rem decrements each cycle; go to RUN on the cycle bub_rem=1. hz is not re-evaluated in this state.
- RUN with none of the above: all control outputs 0.
- Counters:
  - Each counter increments when its qualifying output is 1, saturating at all-ones.
  - clr_cnt=1 zeroes both counters and overrides any increment that cycle.
  - Counters are not affected by mem_timeout.
- Register x0 never causes a hazard.

Test Plan:
1. LOAD_BUBBLES=1: load writes x5 in EX while ID reads rs1=x5 -> exactly 1 cycle of pc_stall=ifid_stall=idex_bubble=1, then 0; stall_cnt=1.
2. LOAD_BUBBLES=3, same hazard -> 3 consecutive bubble cycles. Repeat with rd=x0 -> 0 bubbles and stall_cnt unchanged.
3. redirect_EX pulse for 1 cycle -> ifid_flush=idex_bubble=1 and pc_stall=0 that cycle; flush_cnt=1. Redirect on the second cycle of a 3-bubble LD_STALL -> flush wins, state returns to RUN, no third bubble.
4. mem_busy held 4 cycles during LD_STALL (bub_rem=2) -> 4 cycles of freeze with idex_bubble=0, then the 2 remaining bubbles; stall_cnt=6 counted from the freeze.
5. MEM_TIMEOUT=4 with mem_busy high for 6 cycles -> mem_timeout rises on the 4th busy cycle and stays 1 after mem_busy drops; clears only on rst_n low.
6. rst_n asserted asynchronously mid-LD_STALL and mid-MEM_WAIT -> all outputs 0 immediately. Also: counter at all-ones stays saturated; clr_cnt coinciding with a stall -> counter reads 0 next cycle.
